// File: rtl/simon_playback_sequencer.sv
// Plays a stored LED pattern: each entry is fetched from pattern memory, lit for
// ON_CYCLES, then followed by OFF_CYCLES of darkness before the next entry.
module simon_playback_sequencer #(
   parameter int          ADDR_W     = 6,
   parameter int          DATA_W     = 4,
   parameter int unsigned ON_CYCLES  = 25000000,
   parameter int unsigned OFF_CYCLES = 12500000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] leds,
   output logic              busy,
   output logic              done
);

   localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int          TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SHOW  = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t              state_reg,    state_next;
   logic [ADDR_W-1:0]   index_reg,    index_next;
   logic [ADDR_W-1:0]   count_reg,    count_next;
   logic [TIMER_W-1:0]  timer_reg,    timer_next;
   logic [DATA_W-1:0]   led_data_reg, led_data_next;
   logic [ADDR_W-1:0]   index_inc;

   assign index_inc = index_reg + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         index_reg    <= '0;
         count_reg    <= '0;
         timer_reg    <= '0;
         led_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         index_reg    <= index_next;
         count_reg    <= count_next;
         timer_reg    <= timer_next;
         led_data_reg <= led_data_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      index_next    = index_reg;
      count_next    = count_reg;
      timer_next    = timer_reg;
      led_data_next = led_data_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  count_next = count;
                  index_next = '0;
                  state_next = FETCH;
               end else begin
                  state_next = DONE;
               end
            end
         end
         FETCH: state_next = LOAD;
         LOAD: begin
            led_data_next = mem_rd_data;
            timer_next    = ON_LOAD;
            state_next    = SHOW;
         end
         SHOW: begin
            if (timer_reg == '0) begin
               timer_next = OFF_LOAD;
               state_next = GAP;
            end else begin
               timer_next = timer_reg - TIMER_W'(1);
            end
         end
         GAP: begin
            if (timer_reg == '0) begin
               // index_inc cannot overflow: index < count_reg <= 2^ADDR_W-1
               if (index_inc < count_reg) begin
                  index_next = index_inc;
                  state_next = FETCH;
               end else begin
                  state_next = DONE;
               end
            end else begin
               timer_next = timer_reg - TIMER_W'(1);
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort && state_reg != IDLE) begin
         state_next = IDLE;
      end
   end

   // Outputs are forced quiet while rst is held, not just after the reset edge.
   assign mem_rd_en = !rst && (state_reg == FETCH);
   assign mem_addr  = rst ? '0 : index_reg;
   assign leds      = (!rst && state_reg == SHOW) ? led_data_reg : '0;
   assign busy      = !rst && (state_reg != IDLE);
   assign done      = !rst && (state_reg == DONE);

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Bench for simon_playback_sequencer: directed scenario table, reset sequences and
// randomized runs against a cycle-timing model derived from the playback rules.
module tb_simon_playback_sequencer;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 4;
   localparam int ON     = 3;
   localparam int OFF    = 2;
   localparam int P      = ON + OFF + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] count;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data = '0;
   logic [DATA_W-1:0] leds;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int n_tests = 0;
   int n_fail  = 0;

   simon_playback_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .count(count),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .leds(leds), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected outputs at cycle t of a run started at cycle 0 with count c, abort at a.
   function automatic void model(input int t, input int c, input int a,
                                 output int rd, output int led, output int bsy,
                                 output int dn, output int adr, output int adr_ok);
      int tend;
      int k;
      int ph;
      tend = 1 + c * P;
      rd = 0; led = 0; bsy = 0; dn = 0; adr = 0; adr_ok = 0;
      if (a >= 1 && a <= tend && t > a) return;
      if (t < 1 || t > tend) return;
      bsy = 1;
      if (t == tend) begin
         dn = 1;
         if (c > 0) begin
            adr = c - 1;
            adr_ok = 1;
         end
         return;
      end
      k  = (t - 1) / P;
      ph = (t - 1) % P;
      adr = k;
      adr_ok = 1;
      rd = (ph == 0) ? 1 : 0;
      if (ph >= 2 && ph < 2 + ON) led = int'(mem[k]);
   endfunction

   task automatic run_scn(input int c, input int a, input int poke, input bit noise,
                          output int reads, output int done_at, output int idle_at,
                          output int n_done);
      int tend;
      int lim;
      int tlast;
      int rd, led, bsy, dn, adr, adr_ok;
      tend    = 1 + c * P;
      lim     = (a >= 1 && a <= tend) ? a : tend;
      tlast   = lim + 3;
      reads   = 0;
      done_at = -1;
      idle_at = -1;
      n_done  = 0;
      for (int t = 0; t <= tlast; t++) begin
         @(posedge clk); #1;
         start = (t == 0) || (t == poke) ||
                 (noise && t >= 1 && t <= lim && $urandom_range(3) == 0);
         if (t == 0)                        count = ADDR_W'(c);
         else if (poke >= 0 && t == poke + 1) count = ADDR_W'(1);
         else if (noise)                    count = ADDR_W'($urandom);
         abort = (t == a);
         @(negedge clk);
         model(t, c, a, rd, led, bsy, dn, adr, adr_ok);
         check($sformatf("c%0d t%0d rd_en", c, t), int'(mem_rd_en), rd);
         check($sformatf("c%0d t%0d leds", c, t), int'(leds), led);
         check($sformatf("c%0d t%0d busy", c, t), int'(busy), bsy);
         check($sformatf("c%0d t%0d done", c, t), int'(done), dn);
         if (adr_ok != 0) check($sformatf("c%0d t%0d addr", c, t), int'(mem_addr), adr);
         if (mem_rd_en) reads++;
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = t;
         end
         if (t >= 1 && !busy && idle_at < 0) idle_at = t;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   typedef struct {
      int count;
      int abort_at;
      int poke_at;
      int d0;
      int exp_reads;
      int exp_done_at;
      int exp_idle_at;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int reads, done_at, idle_at, n_done;
      int c, a, tend;

      vecs[0] = '{3,  -1, -1, 1, 3,   22,  23};   // normal playback
      vecs[1] = '{0,  -1, -1, 1, 0,   1,   2};    // empty pattern
      vecs[2] = '{3,  11, -1, 1, 2,   -1,  12};   // abort mid-run
      vecs[3] = '{3,  -1, 5,  1, 3,   22,  23};   // start/count ignored while busy
      vecs[4] = '{1,  -1, -1, 2, 1,   8,   9};    // single entry
      vecs[5] = '{63, -1, -1, 1, 63,  442, 443};  // largest count
      vecs[6] = '{1,  8,  -1, 2, 1,   8,   9};    // abort while in DONE
      vecs[7] = '{2,  0,  -1, 1, 2,   15,  16};   // start+abort together in IDLE

      rst = 1'b1; start = 1'b1; abort = 1'b1; count = ADDR_W'(5);
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);

      // Reset holds outputs quiet and wins over start/abort.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("in_reset%0d busy", i), int'(busy), 0);
         check($sformatf("in_reset%0d outs", i),
               int'(mem_rd_en) + int'(leds) + int'(done) + int'(mem_addr), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("post_reset busy", int'(busy), 0);
      check("post_reset done", int'(done), 0);
      check("post_reset rd_en", int'(mem_rd_en), 0);
      check("post_reset addr", int'(mem_addr), 0);
      check("post_reset leds", int'(leds), 0);

      for (int v = 0; v < 8; v++) begin
         mem[0] = DATA_W'(vecs[v].d0);
         mem[1] = 4'b0100;
         mem[2] = 4'b1000;
         run_scn(vecs[v].count, vecs[v].abort_at, vecs[v].poke_at, 1'b0,
                 reads, done_at, idle_at, n_done);
         check($sformatf("vec%0d reads", v), reads, vecs[v].exp_reads);
         check($sformatf("vec%0d done_at", v), done_at, vecs[v].exp_done_at);
         check($sformatf("vec%0d idle_at", v), idle_at, vecs[v].exp_idle_at);
         check($sformatf("vec%0d n_done", v), n_done, (vecs[v].exp_done_at >= 0) ? 1 : 0);
         $display("[TB] vec %0d count=%0d abort=%0d reads=%0d done_at=%0d idle_at=%0d",
                  v, vecs[v].count, vecs[v].abort_at, reads, done_at, idle_at);
      end

      // Reset mid-run, then a fresh single-entry run.
      mem[0] = 4'b0010;
      reads = 0; n_done = 0;
      for (int t = 0; t <= 17; t++) begin
         @(posedge clk); #1;
         start = (t == 0) || (t == 7);
         count = (t == 0) ? ADDR_W'(3) : ((t == 7) ? ADDR_W'(1) : ADDR_W'(0));
         rst   = (t == 4);
         @(negedge clk);
         if (t == 4 || t == 5) begin
            check($sformatf("rstrun t%0d busy", t), int'(busy), 0);
            check($sformatf("rstrun t%0d outs", t),
                  int'(mem_rd_en) + int'(leds) + int'(done) + int'(mem_addr), 0);
         end
         if (t == 8) begin
            check("rstrun t8 rd_en", int'(mem_rd_en), 1);
            check("rstrun t8 addr", int'(mem_addr), 0);
         end
         if (t == 10) check("rstrun t10 leds", int'(leds), 2);
         if (t == 15) check("rstrun t15 done", int'(done), 1);
         if (t == 16) check("rstrun t16 busy", int'(busy), 0);
         if (mem_rd_en) reads++;
         if (done) n_done++;
      end
      rst = 1'b0; start = 1'b0;
      check("rstrun reads", reads, 2);
      check("rstrun n_done", n_done, 1);
      $display("[TB] reset-mid-run reads=%0d dones=%0d", reads, n_done);

      for (int r = 0; r < 25; r++) begin
         c = $urandom_range(7);
         tend = 1 + c * P;
         a = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(tend, 1));
         for (int i = 0; i < 8; i++) mem[i] = DATA_W'($urandom);
         run_scn(c, a, -1, 1'b1, reads, done_at, idle_at, n_done);
         $display("[TB] rand %0d count=%0d abort=%0d reads=%0d done_at=%0d",
                  r, c, a, reads, done_at);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
